// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants used by fetch and decode,
// fetch FSM encoding, fetch fault causes and the NOP instruction word.
package riscv_pkg;

  localparam logic [6:0] LW    = 7'b000_0011;
  localparam logic [6:0] SW    = 7'b010_0011;
  localparam logic [6:0] BEQ   = 7'b110_0011;
  localparam logic [6:0] I_ALU = 7'b001_0011;
  localparam logic [6:0] R_ALU = 7'b011_0011;
  localparam logic [6:0] JAL   = 7'b110_1111;
  localparam logic [6:0] JALR  = 7'b110_0111;
  localparam logic [6:0] LUI   = 7'b011_0111;
  localparam logic [6:0] AUIPC = 7'b001_0111;

  localparam int NUM_LEGAL_OPS = 9;
  localparam logic [6:0] LEGAL_OPS [NUM_LEGAL_OPS] = '{
    LW, SW, BEQ, I_ALU, R_ALU, JAL, JALR, LUI, AUIPC
  };

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } fault_cause_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request held until a one-cycle ack strobe.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_timer.sv
// Wait-cycle counter for an outstanding fetch; tc flags the last allowed cycle.
module fetch_timer #(
  parameter int TIMEOUT = 16,
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Holds at terminal count so it can never wrap back into a legal window
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !tc) begin
      count_next = count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: issues a word read at PC, latches the reply in IR,
// tracks PC/OldPC and reports misaligned-PC and memory-timeout faults.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_start,
  input  logic                      pc_we,
  input  logic [31:0]               pc_next,
  input  logic                      fault_clr,
  instr_fetch_unit_if.master        mem,
  output logic [31:0]               instr,
  output logic [6:0]                op,
  output logic                      op_legal,
  output logic [31:0]               pc,
  output logic [31:0]               old_pc,
  output logic                      instr_valid,
  output logic                      busy,
  output logic                      fault,
  output logic [1:0]                fault_cause
);

  fetch_state_t state_reg,   state_next;
  fault_cause_t cause_reg,   cause_next;
  logic [31:0]  pc_val_reg,  pc_val_next;
  logic [31:0]  old_pc_reg,  old_pc_next;
  logic [31:0]  instr_reg,   instr_next;
  logic [31:0]  addr_reg,    addr_next;
  logic         valid_reg,   valid_next;

  logic [31:0]  fetch_addr;
  logic         timer_tc;
  logic [NUM_LEGAL_OPS-1:0] op_hit;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg != ST_REQ),
    .enable (state_reg == ST_REQ),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cause_reg  <= CAUSE_NONE;
      pc_val_reg <= RESET_PC;
      old_pc_reg <= RESET_PC;
      instr_reg  <= NOP_INSTR;
      addr_reg   <= RESET_PC;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cause_reg  <= cause_next;
      pc_val_reg <= pc_val_next;
      old_pc_reg <= old_pc_next;
      instr_reg  <= instr_next;
      addr_reg   <= addr_next;
      valid_reg  <= valid_next;
    end
  end

  // A branch target arriving with fetch_start is fetched directly
  assign fetch_addr = pc_we ? pc_next : pc_val_reg;

  always_comb begin
    state_next  = state_reg;
    cause_next  = cause_reg;
    pc_val_next = pc_val_reg;
    old_pc_next = old_pc_reg;
    instr_next  = instr_reg;
    addr_next   = addr_reg;
    valid_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (fetch_start) begin
          pc_val_next = fetch_addr;
          if (fetch_addr[1:0] != 2'b00) begin
            state_next = ST_FAULT;
            cause_next = CAUSE_MISALIGN;
          end else begin
            state_next = ST_REQ;
            addr_next  = fetch_addr;
          end
        end else if (pc_we) begin
          pc_val_next = pc_next;
        end
      end

      ST_REQ: begin
        // Ack checked first: it wins over an expiring timer
        if (mem.mem_ack) begin
          instr_next  = mem.mem_rdata;
          old_pc_next = addr_reg;
          pc_val_next = addr_reg + 32'd4;
          valid_next  = 1'b1;
          state_next  = ST_IDLE;
        end else if (timer_tc) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      ST_FAULT: begin
        if (fault_clr) begin
          state_next = ST_IDLE;
          cause_next = CAUSE_NONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_op_match
    assign op_hit[gi] = (instr_reg[6:0] == LEGAL_OPS[gi]);
  end

  assign mem.mem_req  = (state_reg == ST_REQ);
  assign mem.mem_addr = addr_reg;

  assign instr       = instr_reg;
  assign op          = instr_reg[6:0];
  assign op_legal    = |op_hit;
  assign pc          = pc_val_reg;
  assign old_pc      = old_pc_reg;
  assign instr_valid = valid_reg;
  assign busy        = (state_reg == ST_REQ);
  assign fault       = (state_reg == ST_FAULT);
  assign fault_cause = cause_reg;

endmodule
